// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared types, round count and GF(2^8) helpers
// Contents: NR_AES128, aes_state_t, aes_word_t, xtime, gf_mul2, gf_mul3.
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_column.sv
// rtl/mix_column.sv - combinational AES MixColumns transform of one 32-bit column
// Ports: col_in  - column [a0 a1 a2 a3], a0 in bits [31:24]
//        col_out - transformed column [b0 b1 b2 b3], b0 in bits [31:24]
module mix_column
    import aes_pkg::*;
(
    input  aes_word_t col_in,
    output aes_word_t col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
    assign col_out[7:0]   = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);

endmodule

// File: rtl/round_tail.sv
// rtl/round_tail.sv - AES-128 round back half: ShiftRows, MixColumns, AddRoundKey, output register
// Ports: clk, rst_n (async active-low)
//        st, in_valid, in_ready, s_data_in, round_key - input beat and block start
//        out_valid, out_ready, r_data_out, out_round, out_last - registered result
module round_tail
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] s_data_in,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] r_data_out,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [3:0]  rnd_q, rnd_d;
    logic        out_valid_q, out_valid_d;
    aes_state_t  data_q, data_d;
    logic [3:0]  round_q, round_d;
    logic        last_q, last_d;

    logic        accept;
    logic [3:0]  cur;
    logic        is_last;
    aes_state_t  sr;
    aes_state_t  mc;

    // rnd == 0 means idle: only a start beat may enter. The output side
    // frees up either when empty or when being drained this cycle.
    assign in_ready = (st || (rnd_q != 4'd0)) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign cur      = st ? 4'd1 : rnd_q;
    assign is_last  = (cur == LAST_ROUND);

    // ShiftRows: byte i = r + 4c; row r rotates left by r columns.
    always_comb begin
        sr = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[127 - 8*(r + 4*c) -: 8] = s_data_in[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        mix_column u_mix_column (
            .col_in  (sr[127 - 32*c -: 32]),
            .col_out (mc[127 - 32*c -: 32])
        );
    end

    always_comb begin
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        round_d     = round_q;
        last_d      = last_q;
        if (accept) begin
            rnd_d       = is_last ? 4'd0 : cur + 4'd1;
            out_valid_d = 1'b1;
            data_d      = (is_last ? sr : mc) ^ round_key;
            round_d     = cur;
            last_d      = is_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q       <= 4'd0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            round_q     <= 4'd0;
            last_q      <= 1'b0;
        end else begin
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            round_q     <= round_d;
            last_q      <= last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign r_data_out = data_q;
    assign out_round  = round_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_round_tail.sv
// tb/tb_round_tail.sv - scoreboard bench for round_tail
module tb_round_tail;

    logic         clk;
    logic         rst_n;
    logic         st;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] s_data_in;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] r_data_out;
    logic [3:0]   out_round;
    logic         out_last;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] R10_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] R10_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
    // Columns placed so that after ShiftRows column 0 = db135345, column 1 = f20a225c.
    localparam logic [127:0] MC_IN   = 128'hdb00005cf2130000000a530000002245;
    localparam logic [127:0] MC_OUT  = 128'h8e4da1bc9fdc589d0000000000000000;

    round_tail #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st         (st),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s_data_in  (s_data_in),
        .round_key  (round_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .r_data_out (r_data_out),
        .out_round  (out_round),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Filler key for zero data: output equals the key regardless of MixColumns.
    function automatic logic [127:0] fill_key(input int n);
        logic [3:0] v;
        v = 4'(n);
        return {32{v}};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic s, input logic [127:0] d, input logic [127:0] k,
                        input logic [127:0] ed, input logic [3:0] er, input logic el,
                        output int waits);
        exp_t e;
        waits = 0;
        st = s; in_valid = 1'b1; s_data_in = d; round_key = k;
        #1;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #2;
            waits++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout actual in_ready=0 required in_ready=1");
            in_valid = 1'b0; st = 1'b0;
        end else begin
            e.d = ed; e.r = er; e.l = el;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0; st = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual round %0d required none", out_round);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", r_data_out, e.d);
                check("out_round", 128'(out_round), 128'(e.r));
                check("out_last", 128'(out_last), 128'(e.l));
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0; st = 1'b0; in_valid = 1'b0;
        s_data_in = '0; round_key = '0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_data", r_data_out, 128'd0);
        check("rst_round", 128'(out_round), 128'd0);
        check("rst_last", 128'(out_last), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'd0);

        // Full block at full throughput.
        @(posedge clk); #1;
        send(1'b1, R1_IN, R1_KEY, R1_OUT, 4'd1, 1'b0, w);
        check("tput_r1", 128'(w), 128'd0);
        send(1'b0, MC_IN, '0, MC_OUT, 4'd2, 1'b0, w);
        check("tput_r2", 128'(w), 128'd0);
        for (int n = 3; n <= 9; n++) begin
            send(1'b0, '0, fill_key(n), fill_key(n), 4'(n), 1'b0, w);
            check("tput_rn", 128'(w), 128'd0);
        end
        send(1'b0, R10_IN, R10_KEY, R10_OUT, 4'd10, 1'b0 | 1'b1, w);
        check("tput_r10", 128'(w), 128'd0);

        // After the final round nothing enters without st.
        in_valid = 1'b1; s_data_in = '0; round_key = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_final_in_ready", 128'(in_ready), 128'd0);
        end
        st = 1'b1;
        #1;
        check("st_in_ready", 128'(in_ready), 128'd1);
        st = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure.
        out_ready = 1'b0;
        send(1'b1, '0, fill_key(11), fill_key(11), 4'd1, 1'b0, w);
        fork
            send(1'b0, '0, fill_key(12), fill_key(12), 4'd2, 1'b0, w);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_valid", 128'(out_valid), 128'd1);
                    check("bp_data", r_data_out, fill_key(11));
                    check("bp_round", 128'(out_round), 128'd1);
                    check("bp_in_ready", 128'(in_ready), 128'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        send(1'b0, '0, fill_key(13), fill_key(13), 4'd3, 1'b0, w);
        check("bp_resume_tput", 128'(w), 128'd0);

        // Restart at round 4.
        send(1'b1, '0, fill_key(14), fill_key(14), 4'd1, 1'b0, w);
        send(1'b0, '0, fill_key(15), fill_key(15), 4'd2, 1'b0, w);
        send(1'b0, MC_IN, '0, MC_OUT, 4'd3, 1'b0, w);

        // Asynchronous reset with a held result.
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        send(1'b1, '0, fill_key(5), fill_key(5), 4'd1, 1'b0, w);
        #1;
        check("pre_reset_valid", 128'(out_valid), 128'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'd0);
        check("async_rst_data", r_data_out, 128'd0);
        check("async_rst_round", 128'(out_round), 128'd0);
        check("async_rst_last", 128'(out_last), 128'd0);
        check("async_rst_in_ready", 128'(in_ready), 128'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(1'b1, R1_IN, R1_KEY, R1_OUT, 4'd1, 1'b0, w);

        repeat (3) @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
